// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM port arbiter.
//   arb_state_e : arbiter FSM states (IDLE = no owner, OWNED = owner holds the port)
//   rr_pick_t   : result of a round-robin search {found, idx}
//   rr_pick()   : first set bit of a request mask at or after a start pointer, wrapping
// Index width is sized for the largest supported requester count (8) so every
// instance shares one index type regardless of NUM_REQ.
package dpram_arb_pkg;

    typedef enum logic {IDLE, OWNED} arb_state_e;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Rotate the mask so startPtr sits at position 0, take the lowest set bit,
    // then rotate the index back. Written as a bounded walk so it works for
    // requester counts that are not powers of two.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] mask,
                                         input logic [IDX_W-1:0]   startPtr,
                                         input int                 n);
        rr_pick_t res;
        int       pos;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (!res.found && k < n) begin
                pos = (int'(startPtr) + k) % n;
                if (mask[pos[IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = pos[IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Bundle of requester-side and RAM-side signals of one arbitrated RAM port.
//   req_i/we_i/addr_i/wdata_i : per-requester requests, packed NUM_REQ wide
//   gnt_o/rvalid_o/rdata_o    : per-requester grant, read-valid and shared read data
//   mem_*                     : the single RAM port driven by the arbiter
// slave  : the arbiter's view
// master : the view of the surrounding system (requesters + RAM)
interface dpram_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ-1:0]            we_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic [NUM_REQ-1:0]            rvalid_o;
    logic [DATA_WIDTH-1:0]         rdata_o;
    logic                          mem_en_o;
    logic                          mem_we_o;
    logic [ADDR_WIDTH-1:0]         mem_addr_o;
    logic [DATA_WIDTH-1:0]         mem_wdata_o;
    logic [DATA_WIDTH-1:0]         mem_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dpram_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   reqMask  : candidate requesters
//   startPtr : first index to consider (search wraps modulo NUM_REQ)
//   found    : some candidate was set
//   winner   : index of the first candidate at or after startPtr
module rr_pick_fixed
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] reqMask,
    input  logic [IDX_W-1:0]   startPtr,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);
    rr_pick_t res;

    // Zero-extend the mask to the package width and run the shared search.
    always_comb begin
        res    = rr_pick(MAX_REQ'(reqMask), startPtr, NUM_REQ);
        found  = res.found;
        winner = res.idx;
    end
endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one dual_port_ram port among NUM_REQ requesters.
// The owner keeps the port for up to MAX_BURST back-to-back accesses while
// anyone else waits; alone it keeps the port indefinitely.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dpram_port_arbiter_if.slave (requests, grants, read data, RAM port)
// Grants are combinational; read data returns one cycle after a read grant.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dpram_port_arbiter_if.slave  bus
);
    localparam int              CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    arb_state_e             state, stateNext;
    logic [IDX_W-1:0]       owner, ownerNext;
    logic [IDX_W-1:0]       rrPtr, rrPtrNext;
    logic [CNT_W-1:0]       burstCnt, burstCntNext;
    logic [NUM_REQ-1:0]     rvalid;
    logic [DATA_WIDTH-1:0]  rdata;

    logic                   grantValid;
    logic [IDX_W-1:0]       grantIdx;
    logic [NUM_REQ-1:0]     gnt;
    logic                   memEn, memWe;
    logic [ADDR_WIDTH-1:0]  memAddr;
    logic [DATA_WIDTH-1:0]  memWdata;

    logic [NUM_REQ-1:0]     ownerMask;
    logic [IDX_W-1:0]       afterOwner;
    logic                   ownerReq, otherReq;
    logic [NUM_REQ-1:0]     pickMask;
    logic [IDX_W-1:0]       pickPtr;
    logic                   pickFound;
    logic [IDX_W-1:0]       pickIdx;

    // When owned, the search starts after the owner and skips it, so a
    // handover never lands back on the outgoing owner.
    assign ownerMask  = NUM_REQ'(1) << owner;
    assign afterOwner = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
    assign ownerReq   = |(bus.req_i & ownerMask);
    assign otherReq   = |(bus.req_i & ~ownerMask);
    assign pickMask   = (state == OWNED) ? (bus.req_i & ~ownerMask) : bus.req_i;
    assign pickPtr    = (state == OWNED) ? afterOwner : rrPtr;

    rr_pick_fixed #(.NUM_REQ(NUM_REQ)) picker (
        .reqMask  (pickMask),
        .startPtr (pickPtr),
        .found    (pickFound),
        .winner   (pickIdx)
    );

    // State register plus the registered read-return path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            rrPtr    <= '0;
            burstCnt <= '0;
            rvalid   <= '0;
            rdata    <= '0;
        end else begin
            state    <= stateNext;
            owner    <= ownerNext;
            rrPtr    <= rrPtrNext;
            burstCnt <= burstCntNext;
            rvalid   <= gnt & ~bus.we_i;
            if (|(gnt & ~bus.we_i)) begin
                rdata <= bus.mem_rdata_i;
            end
        end
    end

    // Next-state: keep the owner while its burst allowance lasts (or nobody
    // else wants the port), otherwise hand over in the same cycle.
    always_comb begin
        stateNext    = state;
        ownerNext    = owner;
        rrPtrNext    = rrPtr;
        burstCntNext = burstCnt;
        grantValid   = 1'b0;
        grantIdx     = owner;
        unique case (state)
            IDLE: begin
                if (pickFound) begin
                    grantValid   = 1'b1;
                    grantIdx     = pickIdx;
                    ownerNext    = pickIdx;
                    burstCntNext = CNT_W'(1);
                    stateNext    = OWNED;
                end
            end
            OWNED: begin
                if (ownerReq && (burstCnt < BURST_MAX || !otherReq)) begin
                    grantValid   = 1'b1;
                    grantIdx     = owner;
                    burstCntNext = (burstCnt == BURST_MAX) ? burstCnt : burstCnt + CNT_W'(1);
                end else begin
                    rrPtrNext = afterOwner;
                    if (pickFound) begin
                        grantValid   = 1'b1;
                        grantIdx     = pickIdx;
                        ownerNext    = pickIdx;
                        burstCntNext = CNT_W'(1);
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs: grant is suppressed while reset is held, then the RAM port is
    // muxed from the granted requester (all zero when nobody is granted).
    always_comb begin
        gnt      = '0;
        memEn    = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWdata = '0;
        if (grantValid && rst_n) begin
            gnt = NUM_REQ'(1) << grantIdx;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                memEn    = 1'b1;
                memWe    = bus.we_i[i];
                memAddr  = bus.addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                memWdata = bus.wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.rvalid_o    = rvalid;
    assign bus.rdata_o     = rdata;
    assign bus.mem_en_o    = memEn;
    assign bus.mem_we_o    = memWe;
    assign bus.mem_addr_o  = memAddr;
    assign bus.mem_wdata_o = memWdata;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Self-checking bench for dpram_port_arbiter with a behavioural RAM on the
// arbitrated port. Expected read returns are queued when a read grant is
// expected and popped one cycle later.
module tb_dpram_port_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int AW        = 8;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    typedef struct {
        logic [NUM_REQ-1:0] rvalid;
        logic [DW-1:0]      rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dpram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dpram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return {24'hC0FFEE, a};
    endfunction

    // Behavioural RAM: preloaded on the first edge, written by the arbiter.
    logic [DW-1:0] ram [256];
    logic          preloaded = 1'b0;

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int a = 0; a < 256; a++) ram[a] <= pattern(AW'(a));
            ram[8'h10] <= 32'hDEAD_BEEF;
            preloaded  <= 1'b1;
        end else if (bus.mem_en_o && bus.mem_we_o) begin
            ram[bus.mem_addr_o] <= bus.mem_wdata_o;
        end
    end

    assign bus.mem_rdata_i = ram[bus.mem_addr_o];

    logic [DW-1:0] shadow [256];
    logic [AW-1:0] addrs  [NUM_REQ];
    logic [DW-1:0] wdatas [NUM_REQ];
    logic [DW-1:0] lastRdata;
    exp_t          sbq [$];
    int            compared   = 0;
    int            mismatched = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic driveBus(input logic [NUM_REQ-1:0] req, input logic [NUM_REQ-1:0] we);
        bus.req_i   = req;
        bus.we_i    = we;
        bus.addr_i  = {addrs[3], addrs[2], addrs[1], addrs[0]};
        bus.wdata_i = {wdatas[3], wdatas[2], wdatas[1], wdatas[0]};
    endtask

    // One cycle: drive at the falling edge, check the read return due from the
    // previous edge, check this cycle's grant and RAM port, queue the next return.
    task automatic applyStimulus(input string tag, input logic rstVal,
                                 input logic [NUM_REQ-1:0] req, input logic [NUM_REQ-1:0] we,
                                 input logic [NUM_REQ-1:0] expGnt);
        exp_t e;
        int   gi;
        @(negedge clk);
        rst_n = rstVal;
        driveBus(req, we);
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput({tag, "/rvalid"}, 64'(bus.rvalid_o), 64'(e.rvalid));
            checkOutput({tag, "/rdata"},  64'(bus.rdata_o),  64'(e.rdata));
        end
        checkOutput({tag, "/gnt"}, 64'(bus.gnt_o), 64'(expGnt));
        gi = -1;
        for (int i = 0; i < NUM_REQ; i++) if (expGnt[i]) gi = i;
        if (gi >= 0) begin
            checkOutput({tag, "/mem_en"},   64'(bus.mem_en_o),   64'(1));
            checkOutput({tag, "/mem_we"},   64'(bus.mem_we_o),   64'(we[gi]));
            checkOutput({tag, "/mem_addr"}, 64'(bus.mem_addr_o), 64'(addrs[gi]));
            if (we[gi]) begin
                checkOutput({tag, "/mem_wdata"}, 64'(bus.mem_wdata_o), 64'(wdatas[gi]));
                shadow[addrs[gi]] = wdatas[gi];
                e.rvalid = '0;
                e.rdata  = lastRdata;
            end else begin
                e.rvalid  = expGnt;
                e.rdata   = shadow[addrs[gi]];
                lastRdata = e.rdata;
            end
        end else begin
            checkOutput({tag, "/mem_en"}, 64'(bus.mem_en_o), 64'(0));
            e.rvalid = '0;
            e.rdata  = lastRdata;
        end
        sbq.push_back(e);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) shadow[a] = pattern(AW'(a));
        shadow[8'h10] = 32'hDEAD_BEEF;
        addrs[0] = 8'h30; addrs[1] = 8'h31; addrs[2] = 8'h10; addrs[3] = 8'h33;
        for (int i = 0; i < NUM_REQ; i++) wdatas[i] = 32'hA000_0000 + DW'(i);
        lastRdata = '0;
        rst_n = 1'b0;
        driveBus(4'b1111, 4'b0000);

        // Reset holds every output quiet even with all requests raised.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst/gnt",    64'(bus.gnt_o),    64'(0));
        checkOutput("rst/mem_en", 64'(bus.mem_en_o), 64'(0));
        checkOutput("rst/rvalid", 64'(bus.rvalid_o), 64'(0));
        checkOutput("rst/rdata",  64'(bus.rdata_o),  64'(0));

        applyStimulus("rst_release", 1'b1, 4'b1111, 4'b0000, 4'b0001);
        applyStimulus("idle0",       1'b1, 4'b0000, 4'b0000, 4'b0000);

        // Single read by requester 2.
        applyStimulus("rd_single", 1'b1, 4'b0100, 4'b0000, 4'b0100);
        applyStimulus("idle1",     1'b1, 4'b0000, 4'b0000, 4'b0000);

        // Write then read the same address back-to-back.
        addrs[2]  = 8'h20;
        wdatas[2] = 32'h1234_5678;
        applyStimulus("wr_b2b", 1'b1, 4'b0100, 4'b0100, 4'b0100);
        applyStimulus("rd_b2b", 1'b1, 4'b0100, 4'b0000, 4'b0100);
        applyStimulus("idle2",  1'b1, 4'b0000, 4'b0000, 4'b0000);

        // Burst limit with two contenders, then one requester alone.
        for (int i = 0; i < 9; i++)
            applyStimulus("burst", 1'b1, 4'b0011, 4'b0000, ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010);
        for (int i = 0; i < 6; i++)
            applyStimulus("alone", 1'b1, 4'b0001, 4'b0000, 4'b0001);
        applyStimulus("idle3", 1'b1, 4'b0000, 4'b0000, 4'b0000);

        // Leave rr_ptr at 2, then pulse all four requesters.
        applyStimulus("rr_seed", 1'b1, 4'b0010, 4'b0000, 4'b0010);
        applyStimulus("idle4",   1'b1, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus("rr_a",    1'b1, 4'b1111, 4'b0000, 4'b0100);
        applyStimulus("rr_b",    1'b1, 4'b1011, 4'b0000, 4'b1000);
        applyStimulus("rr_c",    1'b1, 4'b0011, 4'b0000, 4'b0001);
        applyStimulus("rr_d",    1'b1, 4'b0010, 4'b0000, 4'b0010);
        applyStimulus("idle5",   1'b1, 4'b0000, 4'b0000, 4'b0000);

        // Reset in the middle of requester 3's burst.
        applyStimulus("own3_a", 1'b1, 4'b1000, 4'b0000, 4'b1000);
        applyStimulus("own3_b", 1'b1, 4'b1000, 4'b0000, 4'b1000);
        @(negedge clk);
        rst_n = 1'b0;
        driveBus(4'b1001, 4'b0000);
        #1;
        checkOutput("midrst/gnt",    64'(bus.gnt_o),    64'(0));
        checkOutput("midrst/mem_en", 64'(bus.mem_en_o), 64'(0));
        checkOutput("midrst/rvalid", 64'(bus.rvalid_o), 64'(0));
        checkOutput("midrst/rdata",  64'(bus.rdata_o),  64'(0));
        sbq.delete();
        lastRdata = '0;
        applyStimulus("rst_release2", 1'b1, 4'b1001, 4'b0000, 4'b0001);
        applyStimulus("post_rst",     1'b1, 4'b1000, 4'b0000, 4'b1000);
        applyStimulus("idle6",        1'b1, 4'b0000, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
